// File: rtl/sentry_smac_axi_responder_if.sv
// AXI4 bus bundle between the SMAC manager and its backing-store responder.
// The slave modport is the responder side; master is the manager side.
interface sentry_smac_axi_responder_if;
  logic         awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [3:0]   awqos;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arqos;
  logic         arvalid;
  logic         arready;
  logic         rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/sentry_smac_axi_responder.sv
// AXI4 slave modelling the SMAC backing store: 128-bit words,
// independent read and write FSMs sharing one store.
module sentry_smac_axi_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic s_axi_clk,
  input  logic s_axi_aresetn,
  sentry_smac_axi_responder_if.slave s_axi
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AHI = DEPTH_LOG2 + 3;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  function automatic idx_t nxt_idx(
    input idx_t i,
    input logic [1:0] burst
  );
    return (burst == 2'b00) ? i : i + idx_t'(1);
  endfunction

  logic [127:0] mem [DEPTH];

  logic         alive_q;
  r_state_e     r_state_q, r_state_d;
  logic         rid_q, rid_d;
  logic [7:0]   rlen_q, rlen_d;
  logic [1:0]   rburst_q, rburst_d;
  idx_t         ridx_q, ridx_d;
  logic [7:0]   rbeat_q, rbeat_d;
  logic [127:0] rdata_q, rdata_d;

  w_state_e     w_state_q, w_state_d;
  logic         bid_q, bid_d;
  logic [7:0]   wlen_q, wlen_d;
  logic [1:0]   wburst_q, wburst_d;
  idx_t         widx_q, widx_d;
  logic [7:0]   wbeat_q, wbeat_d;
  logic         err_q, err_d;
  logic         over_q, over_d;
  logic         we;

  logic unused_ok;
  assign unused_ok = ^{
    s_axi.awsize, s_axi.awlock, s_axi.awcache,
    s_axi.awprot, s_axi.awqos,
    s_axi.awaddr[31:AHI+1], s_axi.awaddr[3:0],
    s_axi.arsize, s_axi.arlock, s_axi.arcache,
    s_axi.arprot, s_axi.arqos,
    s_axi.araddr[31:AHI+1], s_axi.araddr[3:0]
  };

  // Readies stay low until the first clock edge after reset release.
  assign s_axi.arready = alive_q & (r_state_q == R_IDLE);
  assign s_axi.rvalid  = (r_state_q == R_BURST);
  assign s_axi.rlast   = s_axi.rvalid & (rbeat_q == rlen_q);
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rdata   = rdata_q;

  assign s_axi.awready = alive_q & (w_state_q == W_IDLE);
  assign s_axi.wready  = (w_state_q == W_DATA);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = {err_q, 1'b0};

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    ridx_d    = ridx_q;
    rbeat_d   = rbeat_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && s_axi.arready) begin
          rid_d     = s_axi.arid;
          rlen_d    = s_axi.arlen;
          rburst_d  = s_axi.arburst;
          ridx_d    = s_axi.araddr[AHI:4];
          rbeat_d   = 8'd0;
          rdata_d   = mem[s_axi.araddr[AHI:4]];
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (s_axi.rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            ridx_d  = nxt_idx(ridx_q, rburst_q);
            rdata_d = mem[nxt_idx(ridx_q, rburst_q)];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    widx_d    = widx_q;
    wbeat_d   = wbeat_q;
    err_d     = err_q;
    over_d    = over_q;
    we        = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.awready) begin
          bid_d     = s_axi.awid;
          wlen_d    = s_axi.awlen;
          wburst_d  = s_axi.awburst;
          widx_d    = s_axi.awaddr[AHI:4];
          wbeat_d   = 8'd0;
          err_d     = 1'b0;
          over_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid) begin
          // Beats past the declared length are swallowed unwritten.
          we      = ~over_q;
          wbeat_d = wbeat_q + 8'd1;
          widx_d  = nxt_idx(widx_q, wburst_q);
          if (over_q) err_d = 1'b1;
          if (s_axi.wlast) begin
            if (wbeat_q != wlen_q) err_d = 1'b1;
            w_state_d = W_RESP;
          end else if (wbeat_q == wlen_q) begin
            over_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk) begin
    if (we) begin
      for (int b = 0; b < 16; b++) begin
        if (s_axi.wstrb[b]) begin
          mem[widx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      alive_q   <= 1'b0;
      r_state_q <= R_IDLE;
      rid_q     <= 1'b0;
      rlen_q    <= 8'd0;
      rburst_q  <= 2'b00;
      ridx_q    <= '0;
      rbeat_q   <= 8'd0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      bid_q     <= 1'b0;
      wlen_q    <= 8'd0;
      wburst_q  <= 2'b00;
      widx_q    <= '0;
      wbeat_q   <= 8'd0;
      err_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      alive_q   <= 1'b1;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      ridx_q    <= ridx_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      widx_q    <= widx_d;
      wbeat_q   <= wbeat_d;
      err_q     <= err_d;
      over_q    <= over_d;
    end
  end
endmodule

// File: tb/tb_sentry_smac_axi_responder.sv
// Directed bench for the SMAC AXI responder: queued expectations,
// independent R and B monitors, hold checks under backpressure.
module tb_sentry_smac_axi_responder;
  logic clk;
  logic rst_n;

  sentry_smac_axi_responder_if s_axi();

  sentry_smac_axi_responder #(
    .DEPTH_LOG2(10)
  ) dut (
    .s_axi_clk    (clk),
    .s_axi_aresetn(rst_n),
    .s_axi        (s_axi.slave)
  );

  typedef struct packed {
    logic         id;
    logic         last;
    logic [127:0] d;
  } rexp_t;

  typedef struct packed {
    logic       id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  int errors = 0;
  int checks = 0;

  logic [127:0] wd [16];
  logic [127:0] ed [16];

  logic         held;
  logic [127:0] held_d;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] ONES = {128{1'b1}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else if (s_axi.rvalid) begin
      if (held) chk("r_hold", s_axi.rdata, held_d);
      if (s_axi.rready) begin
        held = 1'b0;
        if (rq.size() == 0) begin
          chk("r_unexpected", 128'd1, 128'd0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", s_axi.rdata, e.d);
          chk("rid", 128'(s_axi.rid), 128'(e.id));
          chk("rlast", 128'(s_axi.rlast), 128'(e.last));
          chk("rresp", 128'(s_axi.rresp), 128'd0);
        end
      end else begin
        held   = 1'b1;
        held_d = s_axi.rdata;
      end
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_axi.bvalid && s_axi.bready) begin
      if (bq.size() == 0) begin
        chk("b_unexpected", 128'd1, 128'd0);
      end else begin
        bexp_t e;
        e = bq.pop_front();
        chk("bresp", 128'(s_axi.bresp), 128'(e.resp));
        chk("bid", 128'(s_axi.bid), 128'(e.id));
      end
    end
  end

  task automatic wait_rdy(input int ch, input string nm);
    int t;
    logic r;
    t = 0;
    forever begin
      @(negedge clk);
      r = (ch == 0) ? s_axi.awready :
          (ch == 1) ? s_axi.wready : s_axi.arready;
      if (r) break;
      t++;
      if (t > 50) begin
        chk({nm, "_timeout"}, 128'd1, 128'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(
    input logic        id,
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [1:0]  burst,
    input int          nb,
    input int          last_at,
    input logic [15:0] strb,
    input logic [1:0]  resp
  );
    int t;
    bq.push_back('{id: id, resp: resp});
    s_axi.awid    = id;
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awburst = burst;
    s_axi.awvalid = 1'b1;
    wait_rdy(0, "aw");
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      s_axi.wdata  = wd[i];
      s_axi.wstrb  = strb;
      s_axi.wlast  = (i == last_at);
      s_axi.wvalid = 1'b1;
      wait_rdy(1, "w");
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    t = 0;
    while (bq.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (bq.size() != 0) begin
      chk("b_timeout", 128'd1, 128'd0);
      bq.delete();
    end
    #1;
  endtask

  task automatic axi_read(
    input logic        id,
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [1:0]  burst,
    input logic        toggle
  );
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{id: id, last: (i == int'(len)), d: ed[i]});
    end
    s_axi.rready  = 1'b1;
    s_axi.arid    = id;
    s_axi.araddr  = addr;
    s_axi.arlen   = len;
    s_axi.arburst = burst;
    s_axi.arvalid = 1'b1;
    wait_rdy(2, "ar");
    s_axi.arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", 128'(s_axi.rvalid), 128'd1);
    t = 0;
    forever begin
      @(posedge clk);
      if (rq.size() == 0) break;
      t++;
      if (t > 100) begin
        chk("r_timeout", 128'd1, 128'd0);
        rq.delete();
        break;
      end
      #1;
      if (toggle) s_axi.rready = ~s_axi.rready;
    end
    #1;
    s_axi.rready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_axi.awid = 0; s_axi.awaddr = 0; s_axi.awlen = 0;
    s_axi.awsize = 3'd4; s_axi.awburst = 2'b01;
    s_axi.awlock = 0; s_axi.awcache = 0;
    s_axi.awprot = 0; s_axi.awqos = 0; s_axi.awvalid = 0;
    s_axi.wdata = 0; s_axi.wstrb = 0;
    s_axi.wlast = 0; s_axi.wvalid = 0;
    s_axi.bready = 1'b1;
    s_axi.arid = 0; s_axi.araddr = 0; s_axi.arlen = 0;
    s_axi.arsize = 3'd4; s_axi.arburst = 2'b01;
    s_axi.arlock = 0; s_axi.arcache = 0;
    s_axi.arprot = 0; s_axi.arqos = 0; s_axi.arvalid = 0;
    s_axi.rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 128'(s_axi.arready), 128'd0);
    chk("rst_awready", 128'(s_axi.awready), 128'd0);
    chk("rst_wready", 128'(s_axi.wready), 128'd0);
    chk("rst_rvalid", 128'(s_axi.rvalid), 128'd0);
    chk("rst_bvalid", 128'(s_axi.bvalid), 128'd0);
    chk("rst_rdata", s_axi.rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_arready_pre", 128'(s_axi.arready), 128'd0);
    @(posedge clk);
    #1;
    chk("rel_arready", 128'(s_axi.arready), 128'd1);
    chk("rel_awready", 128'(s_axi.awready), 128'd1);

    // single beat
    wd[0] = A5;
    axi_write(1'b0, 32'h40, 8'd0, 2'b01, 1, 0, 16'hFFFF, 2'b00);
    ed[0] = A5;
    axi_read(1'b1, 32'h40, 8'd0, 2'b01, 1'b0);

    // 16-beat INCR
    for (int i = 0; i < 16; i++) wd[i] = 128'(i);
    axi_write(1'b1, 32'h100, 8'd15, 2'b01, 16, 15, 16'hFFFF, 2'b00);
    for (int i = 0; i < 16; i++) ed[i] = 128'(i);
    axi_read(1'b0, 32'h100, 8'd15, 2'b01, 1'b0);

    // rready toggling
    axi_read(1'b1, 32'h100, 8'd3, 2'b01, 1'b1);

    // partial strobe
    wd[0] = ONES;
    axi_write(1'b0, 32'h200, 8'd0, 2'b01, 1, 0, 16'hFFFF, 2'b00);
    wd[0] = 128'd0;
    axi_write(1'b0, 32'h200, 8'd0, 2'b01, 1, 0, 16'h000F, 2'b00);
    ed[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000;
    axi_read(1'b0, 32'h200, 8'd0, 2'b01, 1'b0);

    // early wlast
    for (int i = 0; i < 4; i++) wd[i] = 128'(16 + i);
    axi_write(1'b0, 32'h300, 8'd3, 2'b01, 4, 3, 16'hFFFF, 2'b00);
    wd[0] = 128'h22;
    wd[1] = 128'h23;
    axi_write(1'b1, 32'h300, 8'd3, 2'b01, 2, 1, 16'hFFFF, 2'b10);
    ed[0] = 128'h22; ed[1] = 128'h23;
    ed[2] = 128'h12; ed[3] = 128'h13;
    axi_read(1'b0, 32'h300, 8'd3, 2'b01, 1'b0);

    // overrun past len
    wd[0] = 128'h77;
    axi_write(1'b0, 32'h410, 8'd0, 2'b01, 1, 0, 16'hFFFF, 2'b00);
    wd[0] = 128'h55;
    wd[1] = 128'h66;
    axi_write(1'b0, 32'h400, 8'd0, 2'b01, 2, 1, 16'hFFFF, 2'b10);
    ed[0] = 128'h55; ed[1] = 128'h77;
    axi_read(1'b0, 32'h400, 8'd1, 2'b01, 1'b0);

    // FIXED burst
    wd[0] = 128'h99;
    axi_write(1'b0, 32'h510, 8'd0, 2'b01, 1, 0, 16'hFFFF, 2'b00);
    wd[0] = 128'h1; wd[1] = 128'h2; wd[2] = 128'h3;
    axi_write(1'b0, 32'h500, 8'd2, 2'b00, 3, 2, 16'hFFFF, 2'b00);
    ed[0] = 128'h3; ed[1] = 128'h3;
    axi_read(1'b0, 32'h500, 8'd1, 2'b00, 1'b0);
    ed[0] = 128'h3; ed[1] = 128'h99;
    axi_read(1'b0, 32'h500, 8'd1, 2'b01, 1'b0);

    // wrap at depth-1
    wd[0] = 128'hAB; wd[1] = 128'hCD;
    axi_write(1'b0, 32'h3FF0, 8'd1, 2'b01, 2, 1, 16'hFFFF, 2'b00);
    ed[0] = 128'hAB; ed[1] = 128'hCD;
    axi_read(1'b1, 32'h3FF0, 8'd1, 2'b01, 1'b0);
    ed[0] = 128'hCD;
    axi_read(1'b0, 32'h4000, 8'd0, 2'b01, 1'b0);

    // reset mid-burst
    s_axi.rready  = 1'b0;
    s_axi.arid    = 1'b1;
    s_axi.araddr  = 32'h100;
    s_axi.arlen   = 8'd7;
    s_axi.arburst = 2'b01;
    s_axi.arvalid = 1'b1;
    wait_rdy(2, "ar_rst");
    s_axi.arvalid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", 128'(s_axi.rvalid), 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_rvalid", 128'(s_axi.rvalid), 128'd0);
    chk("rst_drop_arready", 128'(s_axi.arready), 128'd0);
    chk("rst_drop_rid", 128'(s_axi.rid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel2_arready", 128'(s_axi.arready), 128'd1);
    ed[0] = A5;
    axi_read(1'b1, 32'h40, 8'd0, 2'b01, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
